// File: rtl/axi_rd_responder.sv
// AXI3 read-channel responder: serves one burst at a time from a backdoor-loaded word memory.
// Optional macro AXI_RD_RESP_ERR_EN: out-of-range beats return SLVERR with zero data.
module axi_rd_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [3:0]        arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic [1:0]        arlock,
  input  logic [3:0]        arcache,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  output logic [3:0]        rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [31:0]       mem_wdata
);

  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam logic [3:0]  LAT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  state_t      r_state, w_nxt_state;
  logic        r_arready, w_nxt_arready;
  logic [3:0]  r_id, w_nxt_id;
  logic [31:0] r_addr, w_nxt_addr;
  logic [8:0]  r_rem, w_nxt_rem;
  logic [2:0]  r_size, w_nxt_size;
  logic        r_fixed, w_nxt_fixed;
  logic [3:0]  r_lat, w_nxt_lat;
  logic        r_rvalid, w_nxt_rvalid;
  logic [31:0] r_rdata, w_nxt_rdata;
  logic [1:0]  r_rresp, w_nxt_rresp;
  logic        r_rlast, w_nxt_rlast;

  logic [31:0] r_mem [DEPTH];

  logic              w_hs;
  logic              w_load;
  logic [31:0]       w_src_addr;
  logic [2:0]        w_src_size;
  logic              w_src_fixed;
  logic [8:0]        w_src_rem;
  logic [31:0]       w_step;
  logic [ADDR_W-1:0] w_idx;
  logic [31:0]       w_mem_rd;
  logic [31:0]       w_beat_data;
  logic [1:0]        w_beat_resp;
  logic              w_unused;

  assign w_unused = ^{arlock, arcache, arprot};

  // Backdoor write port; memory is intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we) r_mem[mem_waddr] <= mem_wdata;
  end

  // In IDLE the first beat (LATENCY=0) comes straight from the AR channel.
  assign w_hs        = arvalid && r_arready;
  assign w_src_addr  = (r_state == S_IDLE) ? araddr : r_addr;
  assign w_src_size  = (r_state == S_IDLE) ? arsize : r_size;
  assign w_src_fixed = (r_state == S_IDLE) ? (arburst == 2'b00) : r_fixed;
  assign w_src_rem   = (r_state == S_IDLE) ? (9'({1'b0, arlen}) + 9'd1) : r_rem;
  assign w_step      = w_src_fixed ? 32'd0 : (32'd1 << w_src_size);
  assign w_idx       = w_src_addr[ADDR_W+1:2];
  assign w_mem_rd    = r_mem[w_idx];

`ifdef AXI_RD_RESP_ERR_EN
  logic w_oor;
  assign w_oor       = |w_src_addr[31:ADDR_W+2];
  assign w_beat_data = w_oor ? 32'd0 : w_mem_rd;
  assign w_beat_resp = w_oor ? 2'b10 : 2'b00;
`else
  assign w_beat_data = w_mem_rd;
  assign w_beat_resp = 2'b00;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_arready <= 1'b1;
      r_id      <= 4'd0;
      r_addr    <= 32'd0;
      r_rem     <= 9'd0;
      r_size    <= 3'd0;
      r_fixed   <= 1'b0;
      r_lat     <= 4'd0;
      r_rvalid  <= 1'b0;
      r_rdata   <= 32'd0;
      r_rresp   <= 2'b00;
      r_rlast   <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_arready <= w_nxt_arready;
      r_id      <= w_nxt_id;
      r_addr    <= w_nxt_addr;
      r_rem     <= w_nxt_rem;
      r_size    <= w_nxt_size;
      r_fixed   <= w_nxt_fixed;
      r_lat     <= w_nxt_lat;
      r_rvalid  <= w_nxt_rvalid;
      r_rdata   <= w_nxt_rdata;
      r_rresp   <= w_nxt_rresp;
      r_rlast   <= w_nxt_rlast;
    end
  end

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_id     = r_id;
    w_nxt_addr   = r_addr;
    w_nxt_rem    = r_rem;
    w_nxt_size   = r_size;
    w_nxt_fixed  = r_fixed;
    w_nxt_lat    = r_lat;
    w_nxt_rvalid = r_rvalid;
    w_nxt_rdata  = r_rdata;
    w_nxt_rresp  = r_rresp;
    w_nxt_rlast  = r_rlast;
    w_load       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          w_nxt_id    = arid;
          w_nxt_addr  = araddr;
          w_nxt_rem   = w_src_rem;
          w_nxt_size  = arsize;
          w_nxt_fixed = (arburst == 2'b00);
          w_nxt_lat   = LAT_LOAD;
          if (LATENCY == 0) w_load = 1'b1;
          else              w_nxt_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_lat == 4'd0) w_load = 1'b1;
        else               w_nxt_lat = r_lat - 4'd1;
      end
      S_BURST: begin
        if (rready) begin
          if (r_rlast) begin
            w_nxt_state  = S_IDLE;
            w_nxt_rvalid = 1'b0;
            w_nxt_rlast  = 1'b0;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase

    // Beat load: capture the word (pre-write value) and advance the beat address.
    if (w_load) begin
      w_nxt_state  = S_BURST;
      w_nxt_rvalid = 1'b1;
      w_nxt_rdata  = w_beat_data;
      w_nxt_rresp  = w_beat_resp;
      w_nxt_rlast  = (w_src_rem == 9'd1);
      w_nxt_rem    = w_src_rem - 9'd1;
      w_nxt_addr   = w_src_addr + w_step;
    end

    w_nxt_arready = (w_nxt_state == S_IDLE);
  end

  assign arready = r_arready;
  assign rid     = r_id;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;
  assign rlast   = r_rlast;
  assign rvalid  = r_rvalid;

endmodule

// File: tb/tb_axi_rd_responder.sv
// Scoreboard bench for axi_rd_responder: AR stimulus pushes expected beats, an R monitor pops and checks.
// Honours AXI_RD_RESP_ERR_EN in its reference model.
module tb_axi_rd_responder;

  localparam int unsigned AW    = 10;
  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          resetn;
  logic [3:0]    arid;
  logic [31:0]   araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid;
  logic          arready;
  logic [3:0]    rid;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;

  axi_rd_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (
    .clk(clk), .resetn(resetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(2'b00), .arcache(4'h0), .arprot(3'h0),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  int          hs_q[$];
  logic [31:0] mdl_mem [DEPTH];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          beats_seen = 0;
  int          rr_mode = 0;

  logic        prev_v = 1'b0;
  logic        stall = 1'b0;
  logic        last_done = 1'b0;
  logic [39:0] saved = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got timeout expected completion (cycle %0d)", nm, cyc);
  endtask

  // rready pattern generator: always-ready, 1,0,0 repeating, or random.
  initial begin
    rready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       rready = 1'b1;
        1:       rready = ((cyc % 3) == 1);
        default: rready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // R-channel monitor.
  always @(negedge clk) begin
    if (!resetn) begin
      prev_v    <= 1'b0;
      stall     <= 1'b0;
      last_done <= 1'b0;
    end else begin
      if (last_done) begin
        chk("post_last_rvalid", 64'(rvalid), 64'd0);
        chk("post_last_arready", 64'(arready), 64'd1);
      end
      if (stall) chk("stall_hold", 64'({rvalid, rid, rdata, rresp, rlast}), 64'(saved));
      if (rvalid && !prev_v) begin
        if (hs_q.size() == 0) fail_now("unexpected_rvalid");
        else chk("first_rvalid_latency", 64'(cyc - hs_q.pop_front()), 64'(1 + LAT));
      end
      last_done <= 1'b0;
      if (rvalid && rready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_beat");
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("r_beat", 64'({rid, rdata, rresp, rlast}), 64'({e.id, e.data, e.resp, e.last}));
        end
        beats_seen <= beats_seen + 1;
        if (rlast) last_done <= 1'b1;
      end
      stall  <= rvalid && !rready;
      saved  <= {rvalid, rid, rdata, rresp, rlast};
      prev_v <= rvalid;
    end
  end

  task automatic preload(input int unsigned idx, input logic [31:0] val);
    @(negedge clk);
    mem_we    = 1'b1;
    mem_waddr = AW'(idx);
    mem_wdata = val;
    mdl_mem[idx] = val;
    @(negedge clk);
    mem_we = 1'b0;
  endtask

  // Reference model: walk the burst in byte addresses and look words up in the model memory.
  task automatic model_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                             input int size, input logic [1:0] burst);
    logic [31:0] a;
    beat_t b;
    a = addr;
    for (int i = 0; i <= len; i++) begin
      b.id   = id;
      b.last = (i == len);
      b.data = mdl_mem[(a / 4) % DEPTH];
      b.resp = 2'b00;
`ifdef AXI_RD_RESP_ERR_EN
      if (a >= 32'(4 * DEPTH)) begin
        b.data = 32'd0;
        b.resp = 2'b10;
      end
`endif
      exp_q.push_back(b);
      if (burst != 2'b00) a = a + (32'd1 << size);
    end
  endtask

  task automatic issue_ar(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int size, input logic [1:0] burst);
    @(negedge clk);
    arid    = id;
    araddr  = addr;
    arlen   = 8'(len);
    arsize  = 3'(size);
    arburst = burst;
    arvalid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (arready) begin
        hs_q.push_back(cyc);
        model_burst(id, addr, len, size, burst);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    arvalid = 1'b0;
    fail_now("ar_accept");
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && hs_q.size() == 0 && !rvalid && arready) return;
    end
    fail_now("burst_done");
    exp_q.delete();
    hs_q.delete();
  endtask

  initial begin
    int base;
    logic [31:0] ra;
    resetn  = 1'b0;
    arvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_rvalid", 64'(rvalid), 64'd0);
    chk("reset_rlast", 64'(rlast), 64'd0);
    chk("reset_rid", 64'(rid), 64'd0);
    chk("reset_rdata", 64'(rdata), 64'd0);
    chk("reset_rresp", 64'(rresp), 64'd0);
    chk("reset_arready", 64'(arready), 64'd1);
    resetn = 1'b1;

    for (int i = 0; i < int'(DEPTH); i++) preload(i, $urandom);

    // Single beat with default latency.
    preload(4, 32'hDEADBEEF);
    issue_ar(4'd3, 32'h10, 0, 2, 2'b01);
    wait_idle();

    // Four back-to-back INCR beats, then the same with stalls.
    for (int i = 0; i < 4; i++) preload(i, 32'(i));
    issue_ar(4'd1, 32'h0, 3, 2, 2'b01);
    wait_idle();
    rr_mode = 1;
    issue_ar(4'd2, 32'h0, 3, 2, 2'b01);
    wait_idle();
    rr_mode = 0;

    // FIXED burst and an out-of-range address.
    issue_ar(4'd4, 32'h8, 2, 2, 2'b00);
    wait_idle();
    issue_ar(4'd5, 32'h4000, 0, 2, 2'b01);
    wait_idle();

    // Reset asserted while beat 2 of 4 is presented.
    base = beats_seen;
    issue_ar(4'd6, 32'h0, 3, 2, 2'b01);
    begin
      bit hit;
      hit = 1'b0;
      for (int n = 0; n < 100 && !hit; n++) begin
        @(negedge clk);
        #1;
        if (beats_seen >= base + 1) hit = 1'b1;
      end
      if (!hit) fail_now("mid_burst_reach");
    end
    @(posedge clk);
    #2;
    chk("pre_reset_rvalid", 64'(rvalid), 64'd1);
    resetn = 1'b0;
    #1;
    chk("mid_reset_rvalid", 64'(rvalid), 64'd0);
    chk("mid_reset_rlast", 64'(rlast), 64'd0);
    chk("mid_reset_arready", 64'(arready), 64'd1);
    exp_q.delete();
    hs_q.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    issue_ar(4'd7, 32'h0, 3, 2, 2'b01);
    wait_idle();

    // Randomized bursts.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) preload($urandom_range(0, DEPTH - 1), $urandom);
      rr_mode = int'($urandom_range(0, 2));
      ra = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 4 * DEPTH - 1));
      issue_ar(4'($urandom), ra,
               ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15)),
               int'($urandom_range(0, 2)), 2'($urandom));
      wait_idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
